// File: rtl/vx_hpdcache_rsp_reorder.sv
// In-order response reorder buffer between core memory port and HPDCache adapter.
// Optional stall counter enabled by defining VX_RSP_REORDER_PERF_EN.
module vx_hpdcache_rsp_reorder #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     core_req_valid,
  input  logic                     core_req_rw,
  input  logic [TAG_WIDTH-1:0]     core_req_tag,
  output logic                     core_req_ready,
  output logic                     mem_req_valid,
  output logic [TAG_WIDTH-1:0]     mem_req_tag,
  input  logic                     mem_req_ready,
  input  logic                     mem_rsp_valid,
  input  logic [TAG_WIDTH-1:0]     mem_rsp_tag,
  input  logic [DATA_WIDTH-1:0]    mem_rsp_data,
  output logic                     mem_rsp_ready,
  output logic                     core_rsp_valid,
  output logic [DATA_WIDTH-1:0]    core_rsp_data,
  output logic [TAG_WIDTH-1:0]     core_rsp_tag,
  input  logic                     core_rsp_ready,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_sticky,
  output logic [31:0]              perf_stall_cycles
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e state_q, state_d;

  logic [IW-1:0]   head_q, head_d;
  logic [IW-1:0]   tail_q, tail_d;
  logic [IW:0]     occ_q, occ_d;
  logic [DEPTH-1:0] alloc_q, alloc_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic            err_q, err_d;

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [TAG_WIDTH-1:0]  ctag_q [DEPTH];

  logic          full;
  logic          accept_ok;
  logic          rd_fire;
  logic          retire;
  logic [IW-1:0] rsp_idx;
  logic          rsp_hi_bad;
  logic          rsp_ok;
  logic          rsp_bad;

  assign full      = (occ_q == (IW+1)'(DEPTH));
  assign accept_ok = (state_q == ST_IDLE) && (core_req_rw || !full);

  assign mem_req_valid  = core_req_valid && accept_ok;
  assign core_req_ready = mem_req_ready && accept_ok;
  assign mem_req_tag    = core_req_rw ? '0 : TAG_WIDTH'(tail_q);
  assign mem_rsp_ready  = 1'b1;

  assign rd_fire = core_req_valid && core_req_ready && !core_req_rw;

  assign rsp_idx    = mem_rsp_tag[IW-1:0];
  assign rsp_hi_bad = ((mem_rsp_tag >> IW) != '0);
  assign rsp_ok     = mem_rsp_valid && !rsp_hi_bad
                    && alloc_q[rsp_idx] && !done_q[rsp_idx];
  assign rsp_bad    = mem_rsp_valid && !rsp_ok;

  assign core_rsp_valid = alloc_q[head_q] && done_q[head_q];
  assign core_rsp_data  = data_q[head_q];
  assign core_rsp_tag   = ctag_q[head_q];
  assign retire         = core_rsp_valid && core_rsp_ready;

  assign drain_done = (state_q == ST_DONE);
  assign occupancy  = occ_q;
  assign err_sticky = err_q;

  always_comb begin
    alloc_d = alloc_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    err_d   = err_q | rsp_bad;
    if (retire) begin
      alloc_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (rsp_ok) begin
      done_d[rsp_idx] = 1'b1;
    end
    // A full buffer blocks reads, so tail never lands on the retiring head
    if (rd_fire) begin
      alloc_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      tail_d          = tail_q + 1'b1;
    end
    unique case ({rd_fire, retire})
      2'b10:   occ_d = occ_q + (IW+1)'(1);
      2'b01:   occ_d = occ_q - (IW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN: if (occ_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      alloc_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      alloc_q <= alloc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Payload storage carries no reset; validity lives in alloc/done
  always_ff @(posedge clk) begin
    if (rsp_ok) begin
      data_q[rsp_idx] <= mem_rsp_data;
    end
    if (rd_fire) begin
      ctag_q[tail_q] <= core_req_tag;
    end
  end

`ifdef VX_RSP_REORDER_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (core_req_valid && !core_req_ready && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_vx_hpdcache_rsp_reorder.sv
// Directed bench for vx_hpdcache_rsp_reorder: ordering, full, stall,
// drain, bad-tag and async reset behaviour.
module tb_vx_hpdcache_rsp_reorder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_req_valid;
  logic        core_req_rw;
  logic [7:0]  core_req_tag;
  logic        core_req_ready;
  logic        mem_req_valid;
  logic [7:0]  mem_req_tag;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [7:0]  mem_rsp_tag;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_ready;
  logic        core_rsp_valid;
  logic [31:0] core_rsp_data;
  logic [7:0]  core_rsp_tag;
  logic        core_rsp_ready;
  logic        drain_req;
  logic        drain_done;
  logic [3:0]  occupancy;
  logic        err_sticky;
  logic [31:0] perf_stall_cycles;

  int n_chk  = 0;
  int n_fail = 0;

  vx_hpdcache_rsp_reorder #(
    .DATA_WIDTH(32),
    .TAG_WIDTH (8),
    .DEPTH     (8)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .core_req_valid   (core_req_valid),
    .core_req_rw      (core_req_rw),
    .core_req_tag     (core_req_tag),
    .core_req_ready   (core_req_ready),
    .mem_req_valid    (mem_req_valid),
    .mem_req_tag      (mem_req_tag),
    .mem_req_ready    (mem_req_ready),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_tag      (mem_rsp_tag),
    .mem_rsp_data     (mem_rsp_data),
    .mem_rsp_ready    (mem_rsp_ready),
    .core_rsp_valid   (core_rsp_valid),
    .core_rsp_data    (core_rsp_data),
    .core_rsp_tag     (core_rsp_tag),
    .core_rsp_ready   (core_rsp_ready),
    .drain_req        (drain_req),
    .drain_done       (drain_done),
    .occupancy        (occupancy),
    .err_sticky       (err_sticky),
    .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic        rw;
    logic [7:0]  rtag;
    logic        sv;
    logic [7:0]  stag;
    logic [31:0] sdat;
    logic        crdy;
    logic        e_qrdy;
    logic [7:0]  e_mtag;
    logic        e_vld;
    logic [7:0]  e_tag;
    logic [31:0] e_dat;
    logic [3:0]  e_occ;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    core_req_valid = 1'b0;
    core_req_rw    = 1'b0;
    core_req_tag   = '0;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b0;
    mem_rsp_tag    = '0;
    mem_rsp_data   = '0;
    core_rsp_ready = 1'b0;
    drain_req      = 1'b0;
  endtask

  task automatic rd(input logic [7:0] t);
    core_req_valid = 1'b1;
    core_req_rw    = 1'b0;
    core_req_tag   = t;
  endtask

  task automatic rsp(input logic [7:0] t, input logic [31:0] d);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = t;
    mem_rsp_data  = d;
  endtask

  localparam logic [31:0] DA = 32'hA0A0_0002;
  localparam logic [31:0] DB = 32'hB0B0_0000;
  localparam logic [31:0] DC = 32'hC0C0_0001;

  initial begin
    int dd_cnt;

    tbl[0] = '{1'b1, 1'b0, 8'h10, 1'b0, 8'h0, 32'h0, 1'b0,
               1'b1, 8'h0, 1'b0, 8'h0, 32'h0, 4'd0};
    tbl[1] = '{1'b1, 1'b0, 8'h11, 1'b0, 8'h0, 32'h0, 1'b0,
               1'b1, 8'h1, 1'b0, 8'h0, 32'h0, 4'd1};
    tbl[2] = '{1'b1, 1'b0, 8'h12, 1'b0, 8'h0, 32'h0, 1'b0,
               1'b1, 8'h2, 1'b0, 8'h0, 32'h0, 4'd2};
    tbl[3] = '{1'b0, 1'b0, 8'h0, 1'b1, 8'h2, DA, 1'b0,
               1'b1, 8'h0, 1'b0, 8'h0, 32'h0, 4'd3};
    tbl[4] = '{1'b0, 1'b0, 8'h0, 1'b1, 8'h0, DB, 1'b0,
               1'b1, 8'h0, 1'b0, 8'h0, 32'h0, 4'd3};
    tbl[5] = '{1'b0, 1'b0, 8'h0, 1'b1, 8'h1, DC, 1'b1,
               1'b1, 8'h0, 1'b1, 8'h10, DB, 4'd3};
    tbl[6] = '{1'b0, 1'b0, 8'h0, 1'b0, 8'h0, 32'h0, 1'b1,
               1'b1, 8'h0, 1'b1, 8'h11, DC, 4'd2};
    tbl[7] = '{1'b0, 1'b0, 8'h0, 1'b0, 8'h0, 32'h0, 1'b1,
               1'b1, 8'h0, 1'b1, 8'h12, DA, 4'd1};
    tbl[8] = '{1'b0, 1'b0, 8'h0, 1'b0, 8'h0, 32'h0, 1'b1,
               1'b1, 8'h0, 1'b0, 8'h0, 32'h0, 4'd0};

    idle();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_occ", occupancy, 0);
    chk("rst_vld", core_rsp_valid, 0);
    chk("rst_dd", drain_done, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_perf", perf_stall_cycles, 0);
    reset_n = 1'b1;

    // out-of-order responses returned in issue order
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      idle();
      core_req_valid = tbl[i].rv;
      core_req_rw    = tbl[i].rw;
      core_req_tag   = tbl[i].rtag;
      mem_rsp_valid  = tbl[i].sv;
      mem_rsp_tag    = tbl[i].stag;
      mem_rsp_data   = tbl[i].sdat;
      core_rsp_ready = tbl[i].crdy;
      #1;
      chk($sformatf("v%0d_qrdy", i), core_req_ready, tbl[i].e_qrdy);
      if (tbl[i].rv) chk($sformatf("v%0d_mtag", i), mem_req_tag, tbl[i].e_mtag);
      chk($sformatf("v%0d_vld", i), core_rsp_valid, tbl[i].e_vld);
      if (tbl[i].e_vld) begin
        chk($sformatf("v%0d_tag", i), core_rsp_tag, tbl[i].e_tag);
        chk($sformatf("v%0d_dat", i), core_rsp_data, tbl[i].e_dat);
      end
      chk($sformatf("v%0d_occ", i), occupancy, tbl[i].e_occ);
    end

    // fill all 8 slots starting at head=tail=3
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle();
      rd(8'h20 + 8'(i));
      #1;
      chk("full_rdy", core_req_ready, 1);
      chk("full_mtag", mem_req_tag, 64'((3 + i) % 8));
      chk("full_occ", occupancy, 64'(i));
    end
    @(negedge clk);
    idle();
    rd(8'h28);
    #1;
    chk("full_block_rdy", core_req_ready, 0);
    chk("full_block_mv", mem_req_valid, 0);
    chk("full_occ8", occupancy, 8);
    core_req_rw = 1'b1;
    #1;
    chk("full_wr_rdy", core_req_ready, 1);
    chk("full_wr_mv", mem_req_valid, 1);
    chk("full_wr_mtag", mem_req_tag, 0);
    @(negedge clk);
    idle();
    rsp(8'd3, 32'hD3);
    @(negedge clk);
    idle();
    core_rsp_ready = 1'b1;
    rd(8'h30);
    #1;
    chk("ret_vld", core_rsp_valid, 1);
    chk("ret_tag", core_rsp_tag, 8'h20);
    chk("ret_same_cyc_rdy", core_req_ready, 0);
    @(negedge clk);
    idle();
    rd(8'h30);
    #1;
    chk("after_ret_rdy", core_req_ready, 1);
    chk("after_ret_mtag", mem_req_tag, 3);
    chk("after_ret_occ", occupancy, 7);

    // complete every slot, then hold the core off
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      idle();
      rsp(8'((4 + j) % 8), 32'h100 + 32'((4 + j) % 8));
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      idle();
      #1;
      chk("stall_vld", core_rsp_valid, 1);
      chk("stall_tag", core_rsp_tag, 8'h21);
      chk("stall_dat", core_rsp_data, 32'h104);
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      idle();
      core_rsp_ready = 1'b1;
      #1;
      chk("drainout_vld", core_rsp_valid, 1);
      chk("drainout_tag", core_rsp_tag, (j < 7) ? 64'(8'h21 + j) : 64'h30);
      chk("drainout_dat", core_rsp_data, 64'(32'h100 + 32'((4 + j) % 8)));
    end
    @(negedge clk);
    idle();
    #1;
    chk("empty_occ", occupancy, 0);
    chk("empty_vld", core_rsp_valid, 0);

    // drain with 3 reads outstanding (slots 4..6)
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      rd(8'h40 + 8'(i));
      #1;
      chk("dr_mtag", mem_req_tag, 64'(4 + i));
    end
    @(negedge clk);
    idle();
    drain_req = 1'b1;
    @(negedge clk);
    idle();
    rd(8'h50);
    #1;
    chk("dr_block_rdy", core_req_ready, 0);
    chk("dr_block_mv", mem_req_valid, 0);
    chk("dr_dd_early", drain_done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      rd(8'h50);
      rsp(8'(4 + i), 32'h400 + 32'(i));
      core_rsp_ready = 1'b1;
      #1;
      chk("dr_blocked", core_req_ready, 0);
    end
    dd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      idle();
      core_rsp_ready = 1'b1;
      #1;
      if (drain_done) dd_cnt++;
    end
    chk("dr_dd_pulses", dd_cnt, 1);
    chk("dr_occ", occupancy, 0);
    @(negedge clk);
    idle();
    core_req_valid = 1'b1;
    core_req_rw    = 1'b1;
    #1;
    chk("dr_resume_rdy", core_req_ready, 1);
    chk("dr_no_err", err_sticky, 0);

    // response to an unallocated slot
    @(negedge clk);
    idle();
    rsp(8'd5, 32'h55);
    @(negedge clk);
    idle();
    #1;
    chk("bad_err", err_sticky, 1);
    chk("bad_occ", occupancy, 0);
    chk("bad_vld", core_rsp_valid, 0);

    // async reset with 4 reads outstanding (slots 7,0,1,2)
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      rd(8'h60 + 8'(i));
    end
    @(negedge clk);
    idle();
    rsp(8'd7, 32'h77);
    @(negedge clk);
    idle();
    #1;
    chk("pre_rst_vld", core_rsp_valid, 1);
    chk("pre_rst_occ", occupancy, 4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_occ", occupancy, 0);
    chk("arst_vld", core_rsp_valid, 0);
    chk("arst_err", err_sticky, 0);
    chk("arst_dd", drain_done, 0);
    chk("arst_perf", perf_stall_cycles, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // drain on an empty buffer pulses two cycles later
    @(negedge clk);
    idle();
    drain_req = 1'b1;
    #1;
    chk("ed_dd0", drain_done, 0);
    @(negedge clk);
    idle();
    #1;
    chk("ed_dd1", drain_done, 0);
    @(negedge clk);
    #1;
    chk("ed_dd2", drain_done, 1);
    @(negedge clk);
    #1;
    chk("ed_dd3", drain_done, 0);

    @(negedge clk);
    idle();
    rd(8'h70);
    #1;
    chk("post_rst_rdy", core_req_ready, 1);
    chk("post_rst_mtag", mem_req_tag, 0);
    @(negedge clk);
    idle();
    #1;
    chk("post_rst_occ", occupancy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_hpdcache_rsp_reorder.md
Name: vx_hpdcache_rsp_reorder

Overview:
- Sits between the Vortex core memory port and the HPDCache request adapter.
- Allocates a slot index per read request and uses it as the tag toward HPDCache.
- Buffers out-of-order HPDCache read responses and returns them to the core strictly in issue order with the original core tag.
- Provides a drain handshake so flush sequencing can wait for all outstanding reads.

Parameters:
- DATA_WIDTH, 32, response data width.
- TAG_WIDTH, 8, core and memory tag width; must be ≥ log2(DEPTH).
- DEPTH, 8, reorder slots; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- core_req_valid  in  1  core request valid.
- core_req_rw  in  1  1 = write (no response expected), 0 = read.
- core_req_tag  in  TAG_WIDTH  core tag.
- core_req_ready  out  1  core request accepted.
- mem_req_valid  out  1  request valid toward adapter.
- mem_req_tag  out  TAG_WIDTH  slot index zero-extended (reads); 0 (writes).
- mem_req_ready  in  1  adapter ready.
- mem_rsp_valid  in  1  HPDCache read response valid.
- mem_rsp_tag  in  TAG_WIDTH  slot index of the response.
- mem_rsp_data  in  DATA_WIDTH  response data.
- mem_rsp_ready  out  1  constant 1.
- core_rsp_valid  out  1  in-order response valid.
- core_rsp_data  out  DATA_WIDTH  response data.
- core_rsp_tag  out  TAG_WIDTH  original core tag.
- core_rsp_ready  in  1  core accepts response.
- drain_req  in  1  pulse: begin drain.
- drain_done  out  1  one-cycle pulse: all reads retired.
- occupancy  out  log2(DEPTH)+1  allocated slots.
- err_sticky  out  1  bad response tag seen.
- perf_stall_cycles  out  32  see Optional Feature.

Behaviour:
- Reset (reset_n=0, async): head=tail=0, all slot alloc/done bits 0, occupancy=0, FSM=IDLE, err_sticky=0, drain_done=0, core_rsp_valid=0, perf counter=0. Slot data/tag arrays are not reset.
- full = (occupancy==DEPTH), evaluated from registered state. A retire in the same cycle does not free a slot for allocation that cycle.
- accept_ok = (FSM==IDLE) && (core_req_rw || !full).
- mem_req_valid = core_req_valid && accept_ok.
- core_req_ready = mem_req_ready && accept_ok.
- Read fire (core_req_valid && core_req_ready && !rw):
  - slot[tail] alloc=1, done=0, stored tag=core_req_tag.
  - mem_req_tag = tail.
  - tail advances modulo DEPTH.
- Write fire: passes through; no slot allocated; mem_req_tag = 0.
- Response (mem_rsp_valid): index = mem_rsp_tag[log2(DEPTH)-1:0].
  - If upper tag bits are nonzero, slot not allocated, or slot already done: discard and set err_sticky=1 (cleared only by reset).
  - Otherwise store data and set done=1.
- core_rsp_valid = alloc[head] && done[head], from registers. Latency: response in cycle N is visible at core no earlier than N+1.
- core_rsp_data/core_rsp_tag come from slot[head]. They hold stable while valid && !ready.
- Retire (core_rsp_valid && core_rsp_ready): clear alloc/done of head; head advances modulo DEPTH.
- occupancy: +1 on read fire, −1 on retire, unchanged when both occur in the same cycle.
- A response to slot k arriving in the same cycle as the retire of slot k cannot occur, because the retiring slot is already done; if it does arrive, it is an error.
- Drain FSM:
  - IDLE: drain_req → DRAIN.
  - DRAIN: all new requests blocked (core_req_ready=0, mem_req_valid=0); responses and retires continue. When occupancy==0 → DONE.
  - DONE: drain_done=1 for one cycle → IDLE.
  - drain_req is ignored outside IDLE.
  - drain_req with occupancy==0 still takes IDLE → DRAIN → DONE, so drain_done pulses 2 cycles after the request.

Optional Feature:
- Macro: VX_RSP_REORDER_PERF_EN.
- Defined: perf_stall_cycles counts cycles with core_req_valid && !core_req_ready. It saturates at 2^32−1 and is reset to 0.
- Undefined: the port exists and is tied to 0; no counter logic is generated.

Test Plan:
- Reads with tags 0x10, 0x11, 0x12 issued as slots 0, 1, 2; responses arrive in slot order 2, 0, 1 with data A, B, C -> core sees (0x10,B), (0x11,C), (0x12,A) in that order; occupancy returns to 0.
- DEPTH=8: issue 8 reads with no responses -> core_req_ready=0 and occupancy=8. A write request is still accepted. One response followed by retire -> next read accepted the cycle after the retire.
- core_rsp_ready held 0 for 5 cycles with head done -> core_rsp_valid=1 and data/tag stable throughout; retire on the first ready cycle.
- 3 reads outstanding, drain_req pulsed -> new requests blocked; after the 3 responses and retires, drain_done is high for exactly 1 cycle; requests then resume.
- Response with tag 5 while slot 5 is unallocated -> discarded, err_sticky=1, occupancy unchanged, no core_rsp_valid.
- reset_n asserted with 4 reads outstanding -> all outputs immediately at reset values; after release, the first read is allocated slot 0.
